// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter in front of the register file write port.
// Define WB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.

module regfile_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  logic [4:0]  rd_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic        wptr;
  logic        rptr;
  logic [1:0]  count;
  logic        push;

  assign push_ready = (count != FULL);
  assign push       = push_valid && push_ready;
  assign head_valid = (count != 2'd0);
  assign head_rd    = rd_mem[rptr];
  assign head_data  = data_mem[rptr];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push)
        wptr <= ~wptr;
      if (pop)
        rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr]   <= push_rd;
      data_mem[wptr] <= push_data;
    end
  end

endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        grant,
  output logic        idle
);

  logic        h0_valid;
  logic        h1_valid;
  logic [4:0]  h0_rd;
  logic [4:0]  h1_rd;
  logic [31:0] h0_data;
  logic [31:0] h1_data;
  logic        sel0;
  logic        sel1;
  logic        any_sel;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        do_write;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk        (clk),
    .areset     (areset),
    .push_valid (req0_valid),
    .push_ready (req0_ready),
    .push_rd    (req0_rd),
    .push_data  (req0_data),
    .pop        (sel0),
    .head_valid (h0_valid),
    .head_rd    (h0_rd),
    .head_data  (h0_data)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk        (clk),
    .areset     (areset),
    .push_valid (req1_valid),
    .push_ready (req1_ready),
    .push_rd    (req1_rd),
    .push_data  (req1_data),
    .pop        (sel1),
    .head_valid (h1_valid),
    .head_rd    (h1_rd),
    .head_data  (h1_data)
  );

`ifdef WB_RR_EN
  // last_grant = 1 after reset so requester 0 wins the first tie.
  logic last_grant;

  always_comb begin
    sel0 = h0_valid && (!h1_valid || last_grant);
    sel1 = h1_valid && (!h0_valid || !last_grant);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)
      last_grant <= 1'b1;
    else if (sel0 || sel1)
      last_grant <= sel1;
  end
`else
  always_comb begin
    sel0 = h0_valid;
    sel1 = h1_valid && !h0_valid;
  end
`endif

  always_comb begin
    any_sel  = sel0 || sel1;
    sel_rd   = 5'd0;
    sel_data = 32'd0;
    unique case (1'b1)
      sel0: begin
        sel_rd   = h0_rd;
        sel_data = h0_data;
      end
      sel1: begin
        sel_rd   = h1_rd;
        sel_data = h1_data;
      end
      default: ;
    endcase
    do_write = any_sel && (sel_rd != 5'd0);
  end

  // x0 entries burn the slot but leave address/data/grant untouched.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      WE3   <= 1'b0;
      A3    <= 5'd0;
      WD3   <= 32'd0;
      grant <= 1'b0;
    end else begin
      WE3 <= do_write;
      if (do_write) begin
        A3    <= sel_rd;
        WD3   <= sel_data;
        grant <= sel1;
      end
    end
  end

  assign idle = !h0_valid && !h1_valid && !WE3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a queue-based model.
// Honours WB_RR_EN the same way the design does.

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        grant;
  logic        idle;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk        (clk),
    .areset     (areset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .grant      (grant),
    .idle       (idle)
  );

  int nvec = 0;
  int nerr = 0;

  logic [36:0] q0[$];
  logic [36:0] q1[$];
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic        m_grant;
`ifdef WB_RR_EN
  logic        m_last;
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_we    = 1'b0;
    m_a3    = 5'd0;
    m_wd3   = 32'd0;
    m_grant = 1'b0;
`ifdef WB_RR_EN
    m_last  = 1'b1;
`endif
  endtask

  // One clock: predict from pre-edge state, advance, compare.
  task automatic step(output bit acc0, output bit acc1);
    bit          r0;
    bit          r1;
    bit          ne0;
    bit          ne1;
    int          sel;
    logic [36:0] e;
    logic [36:0] e0;
    logic [36:0] e1;
    r0 = q0.size() < 2;
    r1 = q1.size() < 2;
    check("req0_ready", 32'(req0_ready), 32'(r0));
    check("req1_ready", 32'(req1_ready), 32'(r1));
    acc0 = req0_valid && r0;
    acc1 = req1_valid && r1;
    e0 = {req0_rd, req0_data};
    e1 = {req1_rd, req1_data};
    ne0 = q0.size() != 0;
    ne1 = q1.size() != 0;
    sel = -1;
`ifdef WB_RR_EN
    if (ne0 && ne1) sel = m_last ? 0 : 1;
    else if (ne0)   sel = 0;
    else if (ne1)   sel = 1;
`else
    if (ne0)        sel = 0;
    else if (ne1)   sel = 1;
`endif
    @(posedge clk);
    #1;
    m_we = 1'b0;
    e = '0;
    if (sel == 0) e = q0.pop_front();
    if (sel == 1) e = q1.pop_front();
    if (sel >= 0) begin
`ifdef WB_RR_EN
      m_last = (sel == 1);
`endif
      if (e[36:32] != 5'd0) begin
        m_we    = 1'b1;
        m_a3    = e[36:32];
        m_wd3   = e[31:0];
        m_grant = (sel == 1);
      end
    end
    if (acc0) q0.push_back(e0);
    if (acc1) q1.push_back(e1);
    check("WE3", 32'(WE3), 32'(m_we));
    if (m_we) begin
      check("A3", 32'(A3), 32'(m_a3));
      check("WD3", WD3, m_wd3);
      check("grant", 32'(grant), 32'(m_grant));
    end
    check("idle", 32'(idle),
          32'(q0.size() == 0 && q1.size() == 0 && !m_we));
  endtask

  task automatic stream(input int n0, input int n1,
                        input logic [4:0] b0, input logic [4:0] b1);
    int i0 = 0;
    int i1 = 0;
    bit a0;
    bit a1;
    for (int c = 0; c < 60 && (i0 < n0 || i1 < n1); c++) begin
      req0_valid = (i0 < n0);
      req0_rd    = b0 + 5'(i0);
      req0_data  = 32'hA000_0000 | (32'(b0) << 8) | 32'(i0);
      req1_valid = (i1 < n1);
      req1_rd    = b1 + 5'(i1);
      req1_data  = 32'hB000_0000 | (32'(b1) << 8) | 32'(i1);
      step(a0, a1);
      if (a0) i0++;
      if (a1) i1++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("stream_done", 32'(i0 == n0 && i1 == n1), 32'd1);
    for (int k = 0; k < 5; k++) step(a0, a1);
  endtask

  initial begin
    bit a0;
    bit a1;
    int p0;
    int p1;
    req0_valid = 1'b0;
    req0_rd    = 5'd0;
    req0_data  = 32'd0;
    req1_valid = 1'b0;
    req1_rd    = 5'd0;
    req1_data  = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_WE3", 32'(WE3), 32'd0);
    check("rst_A3", 32'(A3), 32'd0);
    check("rst_WD3", WD3, 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd1);
    check("rst_ready1", 32'(req1_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    areset = 1'b1;

    // Single write: latency from accept edge to visible write.
    req0_valid = 1'b1;
    req0_rd    = 5'd5;
    req0_data  = 32'hDEADBEEF;
    step(a0, a1);
    req0_valid = 1'b0;
    step(a0, a1);
    check("lat_WE3", 32'(WE3), 32'd1);
    check("lat_A3", 32'(A3), 32'd5);
    check("lat_WD3", WD3, 32'hDEADBEEF);
    check("lat_grant", 32'(grant), 32'd0);
    step(a0, a1);
    check("lat_idle", 32'(idle), 32'd1);

    // x0 write is swallowed.
    req1_valid = 1'b1;
    req1_rd    = 5'd0;
    req1_data  = 32'h1234;
    step(a0, a1);
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) step(a0, a1);
    check("x0_idle", 32'(idle), 32'd1);

    // Back-pressure with both requesters, then continuous streams.
    stream(3, 2, 5'd7, 5'd20);
    stream(4, 4, 5'd1, 5'd11);

    // Async reset while both FIFOs are loaded.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_rd   = 5'(1 + k);
      req0_data = 32'hC000_0000 | 32'(k);
      req1_rd   = 5'(16 + k);
      req1_data = 32'hD000_0000 | 32'(k);
      step(a0, a1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    areset = 1'b0;
    #1;
    check("arst_WE3", 32'(WE3), 32'd0);
    check("arst_ready0", 32'(req0_ready), 32'd1);
    check("arst_ready1", 32'(req1_ready), 32'd1);
    check("arst_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    areset = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) step(a0, a1);

    // Simultaneous first pushes into empty FIFOs.
    stream(1, 1, 5'd3, 5'd9);

    // Random traffic with protocol-correct holding of unaccepted writes.
    a0 = 1'b1;
    a1 = 1'b1;
    for (int blk = 0; blk < 6; blk++) begin
      p0 = $urandom_range(20, 100);
      p1 = $urandom_range(20, 100);
      for (int c = 0; c < 100; c++) begin
        if (!req0_valid || a0) begin
          req0_valid = ($urandom % 100) < p0;
          req0_rd    = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
          req0_data  = $urandom;
        end
        if (!req1_valid || a1) begin
          req1_valid = ($urandom % 100) < p1;
          req1_rd    = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
          req1_data  = $urandom;
        end
        step(a0, a1);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) step(a0, a1);
    check("end_idle", 32'(idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port (WE3/A3/WD3) between two write-back requesters: requester 0 is the ALU write-back path and requester 1 is the load/multi-cycle unit path. Each requester has a 2-entry input FIFO with a valid/ready handshake. An arbiter drains the FIFOs into a registered output stage that drives the register file write port directly. Writes addressed to x0 are consumed and never reach the register file.

## Interface
Parameters:
- DEPTH, 2, entries per requester FIFO; fixed at 2, and the pointer widths assume it.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- areset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write.
- req0_ready  out  1  FIFO 0 not full; a transfer happens when valid && ready at the clock edge.
- req0_rd  in  5  destination register index.
- req0_data  in  32  write data.
- req1_valid, req1_ready, req1_rd, req1_data  same as requester 0, for requester 1.
- WE3  out  1  register file write enable.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.
- grant  out  1  source of the current WE3 write: 0 for requester 0, 1 for requester 1.
- idle  out  1  both FIFOs empty and WE3 low.

## Operation
- Each FIFO holds {rd, data}. It uses 1-bit read/write pointers plus a 2-bit count.
  - Push on valid && ready.
  - Pop when the arbiter selects that FIFO.
  - readyN = (countN != 2), computed from the registered count only. A full FIFO does not accept a push in the same cycle it pops.
- The arbiter is combinational over the FIFO head entries. In each cycle it selects at most one non-empty FIFO and pops its head.
  - Selected head with rd != 0: on the next edge, WE3=1, A3=rd, WD3=data, grant=source.
  - Selected head with rd == 0: the entry is popped and WE3=0 on the next edge (the write is discarded). The arbitration slot is still used and counts for round-robin.
  - No FIFO selected: WE3=0 on the next edge. A3, WD3 and grant hold their previous values.
- Output stage: WE3, A3, WD3 and grant are registers, refreshed every cycle as described above.
- Arbitration policy: see Configuration.
- Order: entries from the same requester reach the port in push order. No ordering exists between requesters. Same-rd conflicts across requesters are resolved upstream.
- idle = (count0==0) && (count1==0) && !WE3.

## Timing
- Reset (areset low, asynchronous) sets:
  - count0, count1, and all pointers to 0
  - WE3=0, A3=0, WD3=0, grant=0
  - req0_ready=1, req1_ready=1, idle=1
  - round-robin last-grant register to 1, so requester 0 has priority first.
- Reset asserted mid-operation flushes all buffered writes. No partial write is issued after reset deasserts.
- Latency: a push accepted at edge N, with no competition, gives WE3 high during the cycle after edge N+1. That is 2 cycles from the accepting edge to the register file write edge (N+2).
- Throughput: one register file write per cycle maximum, shared between requesters. A single requester streaming alone gets 1 write/cycle.
- Simultaneous push and pop on the same FIFO with count 1 leaves the count at 1 and keeps FIFO order.
- Simultaneous valid on both requesters with both FIFOs empty: both pushes are accepted in the same cycle.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - When both FIFOs are non-empty, grant the requester that was not granted in the most recent slot that had a pop.
  - The last-grant register updates only on a pop; x0 discards count as a pop.
- WB_RR_EN undefined: fixed priority.
  - Requester 0 always wins when non-empty.
  - The last-grant register is not implemented.
  - Requester 1 can starve while requester 0 streams.

## Test plan
- Reset, then a single push req0 (rd=5, data=0xDEADBEEF) at edge 1: WE3=1, A3=5, WD3=0xDEADBEEF, grant=0 during the cycle after edge 2; idle=1 after edge 3.
- Push req1 (rd=0, data=0x1234): the entry is popped, WE3 stays 0 throughout, and idle returns to 1.
- Fill FIFO 0 with two entries while the arbiter is busy with requester 1: req0_ready=0. A third valid held high is accepted only after a pop. All three writes appear in push order.
- Both requesters stream continuously (rd 1..4 on req0, rd 11..14 on req1):
  - WB_RR_EN defined: grants alternate 0,1,0,1…
  - WB_RR_EN undefined: all req0 writes come first, then req1.
- Assert areset for 1 cycle while both FIFOs hold 2 entries: WE3=0 immediately (asynchronously), both ready=1, and no write occurs after release.
- Push on req0 and req1 in the same cycle, both FIFOs empty, WB_RR_EN defined: the first write has grant=0, the next write has grant=1, on consecutive cycles.
